// File: rtl/bcd_display_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with
// registered active-low 7-segment outputs, leading-zero blanking and overflow.
module bcd_display_seq #(
   parameter int unsigned BIN_W    = 12,
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned BLANK_LZ = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [7*DIGITS-1:0]   seg_out
);

   localparam int unsigned NI   = (BIN_W * 302) / 1000 + 1;
   localparam int unsigned DMAX = (NI > DIGITS) ? NI : DIGITS;
   localparam int unsigned CW   = $clog2(BIN_W + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              state, state_nx;
   logic [BIN_W-1:0]    sreg;
   logic [4*NI-1:0]     acc, acc_adj, acc_sh;
   logic [4*NI:0]       acc_wide;
   logic [CW-1:0]       cnt;
   logic                last;
   logic [4*DMAX-1:0]   ext;
   logic                ovf_nx;
   logic                lead;
   logic [7*DIGITS-1:0] seg_nx;

   // Active-high g..a pattern for one decimal digit
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0111111;
         4'd1:    seg7 = 7'b0000110;
         4'd2:    seg7 = 7'b1011011;
         4'd3:    seg7 = 7'b1001111;
         4'd4:    seg7 = 7'b1100110;
         4'd5:    seg7 = 7'b1101101;
         4'd6:    seg7 = 7'b1111101;
         4'd7:    seg7 = 7'b0000111;
         4'd8:    seg7 = 7'b1111111;
         4'd9:    seg7 = 7'b1100111;
         default: seg7 = 7'b0000000;
      endcase
   endfunction

   assign busy = (state == SHIFT);
   assign last = (cnt == CW'(1));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = SHIFT;
         SHIFT:   if (last)  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Add-3 correction followed by the one-bit left shift, then the final-result decode
   always_comb begin
      acc_adj = acc;
      for (int unsigned i = 0; i < NI; i++) begin
         if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
      acc_wide = {acc_adj, sreg[BIN_W-1]};
      acc_sh   = acc_wide[4*NI-1:0];

      ext = '0;
      ext[4*NI-1:0] = acc_sh;

      // A carry out of the top accumulator digit would also be lost precision
      ovf_nx = acc_wide[4*NI];
      for (int unsigned i = 0; i < DMAX - DIGITS; i++) begin
         if (ext[4*(DIGITS+i) +: 4] != 4'd0) ovf_nx = 1'b1;
      end

      lead   = (BLANK_LZ != 0);
      seg_nx = '1;
      for (int unsigned j = 0; j < DIGITS; j++) begin
         if (ovf_nx) begin
            seg_nx[7*(DIGITS-1-j) +: 7] = 7'b0111111;
         end else if (lead && ext[4*(DIGITS-1-j) +: 4] == 4'd0 && j != DIGITS - 1) begin
            seg_nx[7*(DIGITS-1-j) +: 7] = 7'h7F;
         end else begin
            lead = 1'b0;
            seg_nx[7*(DIGITS-1-j) +: 7] = ~seg7(ext[4*(DIGITS-1-j) +: 4]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg     <= '0;
         acc      <= '0;
         cnt      <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
         bcd_out  <= '0;
         seg_out  <= '1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sreg <= bin_in;
                  acc  <= '0;
                  cnt  <= CW'(BIN_W);
               end
            end
            SHIFT: begin
               acc  <= acc_sh;
               sreg <= sreg << 1;
               cnt  <= cnt - CW'(1);
               if (last) begin
                  done     <= 1'b1;
                  overflow <= ovf_nx;
                  bcd_out  <= ext[4*DIGITS-1:0];
                  seg_out  <= seg_nx;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_display_seq.sv
// Scoreboard bench for bcd_display_seq: a 4-digit and a 3-digit instance
// with hand-computed BCD and active-low segment expectations.
module tb_bcd_display_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, start_b;
   logic [11:0] bin_a, bin_b;
   logic        busy_a, done_a, ovf_a;
   logic        busy_b, done_b, ovf_b;
   logic [15:0] bcd_a;
   logic [27:0] seg_a;
   logic [11:0] bcd_b;
   logic [20:0] seg_b;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0] bcd;
      logic [27:0] seg;
      logic        ovf;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   always #5 clk = ~clk;

   bcd_display_seq #(.BIN_W(12), .DIGITS(4), .BLANK_LZ(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a),
      .busy(busy_a), .done(done_a), .overflow(ovf_a),
      .bcd_out(bcd_a), .seg_out(seg_a)
   );

   bcd_display_seq #(.BIN_W(12), .DIGITS(3), .BLANK_LZ(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b),
      .busy(busy_b), .done(done_b), .overflow(ovf_b),
      .bcd_out(bcd_b), .seg_out(seg_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (done_a === 1'b1) begin
            if (qa.size() == 0) begin
               chk("a_unexpected_done", 64'(1), 64'(0));
            end else begin
               e = qa.pop_front();
               chk("a_bcd", 64'(bcd_a), 64'(e.bcd));
               chk("a_seg", 64'(seg_a), 64'(e.seg));
               chk("a_ovf", 64'(ovf_a), 64'(e.ovf));
            end
         end
         if (done_b === 1'b1) begin
            if (qb.size() == 0) begin
               chk("b_unexpected_done", 64'(1), 64'(0));
            end else begin
               e = qb.pop_front();
               chk("b_bcd", 64'(bcd_b), 64'(e.bcd));
               chk("b_seg", 64'(seg_b), 64'(e.seg));
               chk("b_ovf", 64'(ovf_b), 64'(e.ovf));
            end
         end
      end
   endtask

   task automatic run_a(input logic [11:0] v, input logic [15:0] eb, input logic [27:0] es);
      logic [15:0] hold;
      int n, bc, chg;
      qa.push_back(exp_t'{bcd: eb, seg: es, ovf: 1'b0});
      start_a = 1'b1;
      bin_a   = v;
      hold    = bcd_a;
      tick();
      start_a = 1'b0;
      n = 0; bc = 0; chg = 0;
      while (n < 40) begin
         if (busy_a) bc++;
         if (done_a) break;
         if (bcd_a !== hold) chg++;
         tick();
         n++;
      end
      chk("a_latency", 64'(n), 64'(12));
      chk("a_busy_cycles", 64'(bc), 64'(12));
      chk("a_stable_during_shift", 64'(chg), 64'(0));
   endtask

   task automatic run_b(input logic [11:0] v, input logic [11:0] eb, input logic [20:0] es,
                        input logic eo);
      int n, bc;
      qb.push_back(exp_t'{bcd: {4'h0, eb}, seg: {7'h00, es}, ovf: eo});
      start_b = 1'b1;
      bin_b   = v;
      tick();
      start_b = 1'b0;
      n = 0; bc = 0;
      while (n < 40) begin
         if (busy_b) bc++;
         if (done_b) break;
         tick();
         n++;
      end
      chk("b_latency", 64'(n), 64'(12));
      chk("b_busy_cycles", 64'(bc), 64'(12));
   endtask

   initial begin
      logic [11:0] v6  [4];
      logic [15:0] b6  [4];
      logic [27:0] s6  [4];
      int n, dn;

      v6 = '{12'd1, 12'd4095, 12'd1, 12'd4095};
      b6 = '{16'h0001, 16'h4095, 16'h0001, 16'h4095};
      s6 = '{{7'h7F, 7'h7F, 7'h7F, 7'h79}, {7'h19, 7'h40, 7'h18, 7'h12},
             {7'h7F, 7'h7F, 7'h7F, 7'h79}, {7'h19, 7'h40, 7'h18, 7'h12}};

      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
      fork
         monitor();
      join_none
      tick();
      tick();
      chk("rst_busy_a", 64'(busy_a), 64'(0));
      chk("rst_done_a", 64'(done_a), 64'(0));
      chk("rst_ovf_a", 64'(ovf_a), 64'(0));
      chk("rst_bcd_a", 64'(bcd_a), 64'(0));
      chk("rst_seg_a", 64'(seg_a), 64'(28'hFFFFFFF));
      chk("rst_seg_b", 64'(seg_b), 64'(21'h1FFFFF));
      rst = 1'b0;
      tick();

      run_a(12'd2047, 16'h2047, {7'h24, 7'h40, 7'h19, 7'h78});

      run_a(12'd0,   16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40});
      run_a(12'd305, 16'h0305, {7'h7F, 7'h30, 7'h40, 7'h12});

      run_b(12'd4095, 12'h095, {7'h3F, 7'h3F, 7'h3F}, 1'b1);
      run_b(12'd999,  12'h999, {7'h18, 7'h18, 7'h18}, 1'b0);

      // Abort mid-conversion: nothing is pushed, so any done pulse is flagged
      start_a = 1'b1;
      bin_a   = 12'd1234;
      tick();
      start_a = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 64'(busy_a), 64'(0));
      chk("abort_done", 64'(done_a), 64'(0));
      chk("abort_bcd", 64'(bcd_a), 64'(0));
      chk("abort_seg", 64'(seg_a), 64'(28'hFFFFFFF));
      chk("abort_ovf", 64'(ovf_a), 64'(0));
      dn = 0;
      repeat (14) begin
         tick();
         if (done_a) dn++;
      end
      chk("abort_no_done", 64'(dn), 64'(0));
      run_a(12'd42, 16'h0042, {7'h7F, 7'h7F, 7'h19, 7'h24});

      qa.push_back(exp_t'{bcd: 16'h0100, seg: {7'h7F, 7'h79, 7'h40, 7'h40}, ovf: 1'b0});
      start_a = 1'b1;
      bin_a   = 12'd100;
      tick();
      bin_a = 12'd777;
      n = 0;
      while (!done_a && n < 40) begin
         start_a = ~start_a;
         tick();
         n++;
      end
      start_a = 1'b0;
      chk("ignore_latency", 64'(n), 64'(12));
      dn = 0;
      repeat (16) begin
         tick();
         if (done_a) dn++;
      end
      chk("ignore_single_done", 64'(dn), 64'(0));

      qa.push_back(exp_t'{bcd: b6[0], seg: s6[0], ovf: 1'b0});
      start_a = 1'b1;
      bin_a   = v6[0];
      tick();
      for (int i = 0; i < 4; i++) begin
         n = 0;
         do begin
            tick();
            n++;
         end while (!done_a && n < 40);
         chk("b2b_period", 64'(n), (i == 0) ? 64'(12) : 64'(13));
         if (i < 3) begin
            qa.push_back(exp_t'{bcd: b6[i+1], seg: s6[i+1], ovf: 1'b0});
            bin_a = v6[i+1];
         end else begin
            start_a = 1'b0;
         end
      end

      repeat (3) tick();
      chk("a_queue_drained", 64'(qa.size()), 64'(0));
      chk("b_queue_drained", 64'(qb.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
